bullet_arbiter: RTL and testbench
=================================

# bullet_arbiter

Allocates the shared pool of on-screen bullet slots between the player cannon and the alien formation. Takes the player's per-frame shoot pulse and the aliens' fire requests, and issues at most one spawn per frame into the bullet datapath. Enforces per-owner cooldowns, one live player bullet, and a slot reserved for the player. Runs on the frame clock alongside the player and alien movement blocks.

## Interface
- NUM_SLOTS, 4, number of bullet slots in the bullet datapath (power of 2, ≥2)
- NUM_ALIENS, 8, number of alien fire requesters (power of 2)
- PLAYER_CD, 10, frames the player must wait after a grant (≥1)
- ALIEN_CD, 30, frames the alien side must wait after any alien grant (≥1)

- frame_clk  in  1  frame-rate clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-low reset
- player_req  in  1  player shoot request, sampled each edge, not latched
- player_X  in  10  player cannon x position at request time
- alien_req  in  NUM_ALIENS  per-alien fire request, sampled each edge, not latched
- alien_X  in  10*NUM_ALIENS  packed alien x positions, alien i at bits [10i+9:10i]
- slot_done  in  NUM_SLOTS  per-slot retire pulse from bullet datapath (hit or off-screen)
- spawn_valid  out  1  one-cycle spawn command
- spawn_slot  out  log2(NUM_SLOTS)  slot to load
- spawn_owner  out  1  0 = player (moves up), 1 = alien (moves down)
- spawn_X  out  10  starting x of the new bullet
- player_grant  out  1  one-cycle pulse, equals spawn_valid & ~spawn_owner
- alien_grant  out  NUM_ALIENS  one-hot pulse naming the granted alien, else 0
- slot_busy  out  NUM_SLOTS  registered occupancy of each slot
- player_live  out  1  a player bullet is in flight

## Operation
- State: slot_busy, slot_owner[NUM_SLOTS], player_cd and alien_cd down-counters, rr_ptr (log2 NUM_ALIENS), and the registered spawn outputs.
- free = ~slot_busy, using the registered value. A slot retired in cycle t is allocatable no earlier than cycle t+1.
- alien_live = number of busy slots with owner 1.
- Allocation: pick the lowest-index free slot. At most one grant per cycle.
- Player eligible: player_req & ~player_live & player_cd==0 & any free.
- Alien eligible: |alien_req & alien_cd==0 & any free & alien_live < NUM_SLOTS-1. One slot is always kept back for the player.
- Priority: the player beats the aliens in the same cycle. The losing alien request is dropped, not queued.
- Alien selection is round-robin: first requesting index scanning upward from rr_ptr with wrap. On grant, rr_ptr ← winner+1 mod NUM_ALIENS. rr_ptr is unchanged when there is no alien grant.
- On a grant:
  - slot_busy[s] ← 1 and slot_owner[s] ← owner.
  - spawn_X ← player_X, or the winner's slice of alien_X.
  - The granting owner's cooldown loads with PLAYER_CD or ALIEN_CD.
  - player_live ← 1 for a player grant.
- Cooldowns decrement by 1 per cycle while nonzero, saturating at 0.
- slot_done[k] with slot_busy[k]=1: slot_busy[k] ← 0. If slot_owner[k]=0, player_live ← 0. slot_done on a non-busy slot is ignored.
- Retire and grant in the same cycle on different slots are both applied. The granted slot is never a retiring slot, because it was already free.
- Reset (asserted low, asynchronous) clears all slots, cooldowns, rr_ptr and player_live. Every output goes to 0, including spawn_slot and spawn_X. Reset mid-flight drops all bullets with no spawn pulse.
- No arithmetic overflow: counters are sized for their CD parameter, and alien_live is a popcount ≤ NUM_SLOTS.

## Timing
- Request sampled at edge t → spawn_valid, spawn_slot, spawn_owner, spawn_X and the grant outputs valid for the cycle after edge t. Latency is 1 cycle.
- spawn_valid is never high in two consecutive cycles with the same slot.
- slot_busy reflects the grant in the same cycle that spawn_valid is high.
- Minimum spacing between player grants is PLAYER_CD+1 cycles, and also requires the prior player bullet's slot_done.
- Minimum spacing between alien grants is ALIEN_CD+1 cycles.
- A player request held high continuously is granted on the first edge where it is eligible.
- Deassertion of Reset is synchronised by the surrounding system. The block acts on the first rising edge after release.

## Test plan
- Reset, then player_req=1 for one cycle with player_X=320 → next cycle spawn_valid=1, slot 0, owner 0, spawn_X=320, player_live=1.
- Player_req held high with no slot_done → no further grant. Pulse slot_done[0] → player_live=0. Next grant occurs once player_cd has reached 0.
- alien_req=8'hFF held, player idle, slots retired on arrival → grants at alien 0, 1, 2… spaced ALIEN_CD+1 cycles apart, wrapping after alien 7.
- Three alien bullets live with NUM_SLOTS=4 → further alien requests are refused. A player_req is still granted slot 3.
- player_req and alien_req[5] in the same eligible cycle → player granted, alien_grant=0, rr_ptr unchanged, alien_cd unchanged.
- Reset low while 3 slots are busy and cooldowns are nonzero → all outputs 0 immediately. After release, player_req is granted slot 0 one cycle later.

Source files
------------

// File: rtl/bullet_arbiter_if.sv
// Bullet arbiter bus: shoot requests in, spawn commands and occupancy out.
interface bullet_arbiter_if #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned NUM_ALIENS = 8
);
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned XW = 10;

  logic                       player_req;
  logic [XW-1:0]              player_X;
  logic [NUM_ALIENS-1:0]      alien_req;
  logic [XW*NUM_ALIENS-1:0]   alien_X;
  logic [NUM_SLOTS-1:0]       slot_done;
  logic                       spawn_valid;
  logic [SW-1:0]              spawn_slot;
  logic                       spawn_owner;
  logic [XW-1:0]              spawn_X;
  logic                       player_grant;
  logic [NUM_ALIENS-1:0]      alien_grant;
  logic [NUM_SLOTS-1:0]       slot_busy;
  logic                       player_live;

  // Requester / bullet datapath side
  modport master (
    output player_req, player_X, alien_req, alien_X, slot_done,
    input  spawn_valid, spawn_slot, spawn_owner, spawn_X,
    input  player_grant, alien_grant, slot_busy, player_live
  );

  // Arbiter side
  modport slave (
    input  player_req, player_X, alien_req, alien_X, slot_done,
    output spawn_valid, spawn_slot, spawn_owner, spawn_X,
    output player_grant, alien_grant, slot_busy, player_live
  );
endinterface

// File: rtl/bullet_arbiter.sv
// Bullet slot arbiter: one spawn per frame, player priority, per-owner
// cooldowns, one live player bullet, and one slot always kept for the player.
module bullet_arbiter #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned NUM_ALIENS = 8,
  parameter int unsigned PLAYER_CD  = 10,
  parameter int unsigned ALIEN_CD   = 30
) (
  input  logic           frame_clk,
  input  logic           Reset,
  bullet_arbiter_if.slave bus
);
  localparam int unsigned SW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned AW  = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;
  localparam int unsigned PCW = $clog2(PLAYER_CD + 1);
  localparam int unsigned ACW = $clog2(ALIEN_CD + 1);
  localparam int unsigned LW  = $clog2(NUM_SLOTS + 1);
  localparam int unsigned XW  = 10;

  logic [NUM_SLOTS-1:0]  slot_busy_q,   slot_busy_d;
  logic [NUM_SLOTS-1:0]  slot_owner_q,  slot_owner_d;
  logic [PCW-1:0]        player_cd_q,   player_cd_d;
  logic [ACW-1:0]        alien_cd_q,    alien_cd_d;
  logic [AW-1:0]         rr_ptr_q,      rr_ptr_d;
  logic                  player_live_q, player_live_d;
  logic                  spawn_valid_q, spawn_valid_d;
  logic [SW-1:0]         spawn_slot_q,  spawn_slot_d;
  logic                  spawn_owner_q, spawn_owner_d;
  logic [XW-1:0]         spawn_x_q,     spawn_x_d;
  logic                  player_grant_q, player_grant_d;
  logic [NUM_ALIENS-1:0] alien_grant_q, alien_grant_d;

  logic [LW-1:0]         alien_live_c;
  logic [SW-1:0]         free_slot_c;
  logic                  any_free_c;
  logic                  alien_found_c;
  logic [AW-1:0]         alien_win_c;
  logic                  player_ok_c;
  logic                  alien_ok_c;

  // Eligibility, slot pick and round-robin winner from registered state
  always_comb begin
    alien_live_c = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      alien_live_c = alien_live_c + LW'(slot_busy_q[k] & slot_owner_q[k]);
    end

    free_slot_c = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!slot_busy_q[k]) free_slot_c = SW'(k);
    end
    any_free_c = ~(&slot_busy_q);

    alien_found_c = 1'b0;
    alien_win_c   = '0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      if (!alien_found_c && bus.alien_req[AW'((int'(rr_ptr_q) + i) % NUM_ALIENS)]) begin
        alien_found_c = 1'b1;
        alien_win_c   = AW'((int'(rr_ptr_q) + i) % NUM_ALIENS);
      end
    end

    player_ok_c = bus.player_req & ~player_live_q & (player_cd_q == '0) & any_free_c;
    // Aliens may never fill the last free slot, so the player always has one.
    alien_ok_c  = alien_found_c & (alien_cd_q == '0) & any_free_c &
                  (alien_live_c < LW'(NUM_SLOTS - 1)) & ~player_ok_c;
  end

  // Next-state: retires, cooldown countdown, then at most one grant
  always_comb begin
    slot_busy_d    = slot_busy_q & ~bus.slot_done;
    slot_owner_d   = slot_owner_q;
    player_live_d  = player_live_q;
    player_cd_d    = (player_cd_q != '0) ? player_cd_q - PCW'(1) : '0;
    alien_cd_d     = (alien_cd_q != '0) ? alien_cd_q - ACW'(1) : '0;
    rr_ptr_d       = rr_ptr_q;
    spawn_valid_d  = 1'b0;
    spawn_slot_d   = spawn_slot_q;
    spawn_owner_d  = spawn_owner_q;
    spawn_x_d      = spawn_x_q;
    player_grant_d = 1'b0;
    alien_grant_d  = '0;

    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (bus.slot_done[k] && slot_busy_q[k] && !slot_owner_q[k]) player_live_d = 1'b0;
    end

    if (player_ok_c) begin
      slot_busy_d[free_slot_c]  = 1'b1;
      slot_owner_d[free_slot_c] = 1'b0;
      player_cd_d               = PCW'(PLAYER_CD);
      player_live_d             = 1'b1;
      spawn_valid_d             = 1'b1;
      spawn_slot_d              = free_slot_c;
      spawn_owner_d             = 1'b0;
      spawn_x_d                 = bus.player_X;
      player_grant_d            = 1'b1;
    end else if (alien_ok_c) begin
      slot_busy_d[free_slot_c]  = 1'b1;
      slot_owner_d[free_slot_c] = 1'b1;
      alien_cd_d                = ACW'(ALIEN_CD);
      rr_ptr_d                  = AW'((int'(alien_win_c) + 1) % NUM_ALIENS);
      spawn_valid_d             = 1'b1;
      spawn_slot_d              = free_slot_c;
      spawn_owner_d             = 1'b1;
      spawn_x_d                 = bus.alien_X[int'(alien_win_c)*XW +: XW];
      alien_grant_d             = NUM_ALIENS'(1) << alien_win_c;
    end
  end

  // State and output registers
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      slot_busy_q    <= '0;
      slot_owner_q   <= '0;
      player_cd_q    <= '0;
      alien_cd_q     <= '0;
      rr_ptr_q       <= '0;
      player_live_q  <= 1'b0;
      spawn_valid_q  <= 1'b0;
      spawn_slot_q   <= '0;
      spawn_owner_q  <= 1'b0;
      spawn_x_q      <= '0;
      player_grant_q <= 1'b0;
      alien_grant_q  <= '0;
    end else begin
      slot_busy_q    <= slot_busy_d;
      slot_owner_q   <= slot_owner_d;
      player_cd_q    <= player_cd_d;
      alien_cd_q     <= alien_cd_d;
      rr_ptr_q       <= rr_ptr_d;
      player_live_q  <= player_live_d;
      spawn_valid_q  <= spawn_valid_d;
      spawn_slot_q   <= spawn_slot_d;
      spawn_owner_q  <= spawn_owner_d;
      spawn_x_q      <= spawn_x_d;
      player_grant_q <= player_grant_d;
      alien_grant_q  <= alien_grant_d;
    end
  end

  assign bus.spawn_valid  = spawn_valid_q;
  assign bus.spawn_slot   = spawn_slot_q;
  assign bus.spawn_owner  = spawn_owner_q;
  assign bus.spawn_X      = spawn_x_q;
  assign bus.player_grant = player_grant_q;
  assign bus.alien_grant  = alien_grant_q;
  assign bus.slot_busy    = slot_busy_q;
  assign bus.player_live  = player_live_q;
endmodule

// File: tb/tb_bullet_arbiter.sv
// Scoreboard bench for bullet_arbiter with a behavioural slot-pool model.
module tb_bullet_arbiter;
  localparam int NS  = 4;
  localparam int NA  = 8;
  localparam int PCD = 10;
  localparam int ACD = 30;

  typedef struct {
    bit v;
    int slot;
    bit owner;
    int x;
    int win;
    int busy;
    bit plive;
    bit rst;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bullet_arbiter_if #(.NUM_SLOTS(NS), .NUM_ALIENS(NA)) bif ();

  bullet_arbiter #(
    .NUM_SLOTS(NS), .NUM_ALIENS(NA), .PLAYER_CD(PCD), .ALIEN_CD(ACD)
  ) dut (
    .frame_clk(clk),
    .Reset(rst_n),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int stim_cyc = 0;
  int mon_cyc  = 0;
  bit mon_en   = 1'b0;
  exp_t status_q[$];
  exp_t spawn_q[$];

  // Reference model: a pool of slots with owners, two cooldown timers,
  // one live-player flag and a round-robin start index.
  bit m_busy[NS];
  bit m_own[NS];
  int m_pcd, m_acd, m_rr;
  bit m_plive;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, mon_cyc);
  endtask

  function automatic logic [NS-1:0] model_busy();
    logic [NS-1:0] v;
    for (int k = 0; k < NS; k++) v[k] = m_busy[k];
    return v;
  endfunction

  // Drive one frame of inputs and record what the arbiter must do on the next edge.
  task automatic cycle(input bit rst, input bit preq, input int px,
                       input logic [NA-1:0] areq, input logic [10*NA-1:0] ax,
                       input logic [NS-1:0] done);
    exp_t e;
    int nfree, alive, s, win;
    bit p_ok, a_ok;
    @(negedge clk);
    rst_n          = rst;
    bif.player_req = preq;
    bif.player_X   = 10'(px);
    bif.alien_req  = areq;
    bif.alien_X    = ax;
    bif.slot_done  = done;
    e = '{default: 0};
    if (!rst) begin
      for (int k = 0; k < NS; k++) begin m_busy[k] = 0; m_own[k] = 0; end
      m_pcd = 0; m_acd = 0; m_rr = 0; m_plive = 0;
      e.rst = 1;
    end else begin
      nfree = 0; alive = 0; s = -1; win = -1;
      for (int k = 0; k < NS; k++) begin
        if (!m_busy[k]) begin nfree++; if (s < 0) s = k; end
        else if (m_own[k]) alive++;
      end
      p_ok = preq && !m_plive && m_pcd == 0 && nfree > 0;
      a_ok = areq != 0 && m_acd == 0 && nfree > 0 && alive < NS - 1 && !p_ok;
      if (a_ok)
        for (int i = 0; i < NA; i++)
          if (win < 0 && areq[(m_rr + i) % NA]) win = (m_rr + i) % NA;
      for (int k = 0; k < NS; k++)
        if (done[k] && m_busy[k]) begin m_busy[k] = 0; if (!m_own[k]) m_plive = 0; end
      if (m_pcd > 0) m_pcd--;
      if (m_acd > 0) m_acd--;
      if (p_ok) begin
        m_busy[s] = 1; m_own[s] = 0; m_pcd = PCD; m_plive = 1;
        e.v = 1; e.slot = s; e.owner = 0; e.x = px % 1024;
      end else if (a_ok) begin
        m_busy[s] = 1; m_own[s] = 1; m_acd = ACD; m_rr = (win + 1) % NA;
        e.v = 1; e.slot = s; e.owner = 1; e.win = win; e.x = int'(ax[win*10 +: 10]);
      end
      e.busy  = int'(model_busy());
      e.plive = m_plive;
    end
    e.cyc = stim_cyc;
    stim_cyc++;
    status_q.push_back(e);
    if (e.v) spawn_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  // Monitor: per-frame status check, spawn records popped when the DUT spawns.
  initial begin
    exp_t e, sp;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (status_q.size() == 0) begin
          n_checks++;
          $display("FAIL status_queue: got empty expected a record (cycle %0d)", mon_cyc);
        end else begin
          e = status_q.pop_front();
          chk("spawn_valid", int'(bif.spawn_valid), int'(e.v));
          chk("slot_busy", int'(bif.slot_busy), e.busy);
          chk("player_live", int'(bif.player_live), int'(e.plive));
          chk("player_grant", int'(bif.player_grant), int'(e.v && !e.owner));
          chk("alien_grant", int'(bif.alien_grant), (e.v && e.owner) ? (1 << e.win) : 0);
          if (e.rst) begin
            chk("rst_spawn_slot", int'(bif.spawn_slot), 0);
            chk("rst_spawn_owner", int'(bif.spawn_owner), 0);
            chk("rst_spawn_X", int'(bif.spawn_X), 0);
          end
          if (bif.spawn_valid) begin
            if (spawn_q.size() == 0) begin
              n_checks++;
              $display("FAIL spawn_unexpected: got spawn slot %0d expected none (cycle %0d)",
                       bif.spawn_slot, mon_cyc);
            end else begin
              sp = spawn_q.pop_front();
              chk("spawn_cycle", mon_cyc, sp.cyc);
              chk("spawn_slot", int'(bif.spawn_slot), sp.slot);
              chk("spawn_owner", int'(bif.spawn_owner), int'(sp.owner));
              chk("spawn_X", int'(bif.spawn_X), sp.x);
            end
          end
          mon_cyc++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10*NA-1:0] ax;
    bif.player_req = 1'b0;
    bif.player_X   = '0;
    bif.alien_req  = '0;
    bif.alien_X    = '0;
    bif.slot_done  = '0;
    ax = '0;
    for (int i = 0; i < NA; i++) ax[i*10 +: 10] = 10'(100 + 7 * i);

    // Reset, then a single player shot at x=320
    cycle(0, 0, 0, 0, ax, 0);
    cycle(0, 0, 0, 0, ax, 0);
    cycle(1, 1, 320, 0, ax, 0);
    peek();
    chk("tp1_valid", int'(bif.spawn_valid), 1);
    chk("tp1_slot", int'(bif.spawn_slot), 0);
    chk("tp1_X", int'(bif.spawn_X), 320);
    chk("tp1_live", int'(bif.player_live), 1);

    // Held request is blocked by the live bullet, then retire and regrant
    for (int i = 0; i < 14; i++) cycle(1, 1, 321, 0, ax, 0);
    cycle(1, 1, 322, 0, ax, 4'b0001);
    peek();
    chk("tp2_live_cleared", int'(bif.player_live), 0);
    cycle(1, 1, 323, 0, ax, 0);
    peek();
    chk("tp2_regrant", int'(bif.player_grant), 1);
    cycle(1, 0, 0, 0, ax, model_busy());

    // All aliens requesting, bullets retired on arrival: round-robin with wrap
    for (int i = 0; i < 9 * (ACD + 1) + 2; i++) cycle(1, 0, 0, 8'hFF, ax, model_busy());

    // Three alien bullets live: aliens refused, player still gets slot 3
    cycle(0, 0, 0, 0, ax, 0);
    for (int i = 0; i < 3 * (ACD + 1) + 5; i++) cycle(1, 0, 0, 8'hFF, ax, 0);
    chk("tp4_alien_busy", int'(bif.slot_busy), 4'b0111);
    cycle(1, 1, 500, 8'hFF, ax, 0);
    peek();
    chk("tp4_player_slot", int'(bif.spawn_slot), 3);
    chk("tp4_player_owner", int'(bif.spawn_owner), 0);

    // Asynchronous reset mid-flight clears everything at once
    cycle(0, 0, 0, 0, ax, 0);
    #1;
    chk("tp6_rst_busy", int'(bif.slot_busy), 0);
    chk("tp6_rst_live", int'(bif.player_live), 0);
    chk("tp6_rst_valid", int'(bif.spawn_valid), 0);
    cycle(1, 1, 77, 0, ax, 0);
    peek();
    chk("tp6_post_rst_slot", int'(bif.spawn_slot), 0);
    chk("tp6_post_rst_valid", int'(bif.spawn_valid), 1);

    // Player and alien 5 together: player wins, alien cooldown untouched
    cycle(0, 0, 0, 0, ax, 0);
    cycle(1, 1, 200, 8'h20, ax, 0);
    peek();
    chk("tp5_player_grant", int'(bif.player_grant), 1);
    chk("tp5_alien_grant", int'(bif.alien_grant), 0);
    cycle(1, 0, 0, 8'h20, ax, 0);
    peek();
    chk("tp5_alien5_next", int'(bif.alien_grant), 8'h20);
    chk("tp5_alien5_X", int'(bif.spawn_X), 135);

    // Randomized traffic with occasional retires and resets
    for (int i = 0; i < 3000; i++) begin
      logic [10*NA-1:0] rx;
      logic [NS-1:0] dn;
      for (int j = 0; j < NA; j++) rx[j*10 +: 10] = 10'($urandom);
      dn = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      cycle(($urandom_range(0, 249) != 0), ($urandom_range(0, 2) == 0), int'($urandom_range(0, 1023)),
            ($urandom_range(0, 1) == 0) ? NA'($urandom) : '0, rx, dn);
    end

    @(posedge clk);
    #3;
    mon_en = 1'b0;
    chk("status_queue_drained", status_q.size(), 0);
    chk("spawn_queue_drained", spawn_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
